// File: rtl/pblaze_intc.sv
// Interrupt controller for the pacoblaze core: synchronised edge/level sources, mask/pending/vector
// registers on the port_id bus, and a REQ/ack/EOI handshake driving the single core interrupt line.
module pblaze_intc #(
    parameter int         NUM_IRQ     = 8,
    parameter logic [7:0] BASE_ADDR   = 8'h10,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [7:0]         port_id,
    input  logic               write_strobe,
    input  logic               read_strobe,
    input  logic [7:0]         out_port,
    output logic [7:0]         in_port,
    output logic               sel,
    output logic               interrupt,
    input  logic               interrupt_ack
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_MASK   = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_CLEAR  = 3'd3;
    localparam logic [2:0] REG_VECTOR = 3'd4;
    localparam logic [2:0] REG_EOI    = 3'd5;
    localparam logic [1:0] FILL_CNT   = 2'(SYNC_STAGES);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] s, s_prev, armed, rise, clr;
    logic [NUM_IRQ-1:0] pending, pending_nxt, mask, mode, act;
    logic [1:0]         fill_cnt;
    logic               filled;
    logic [7:0]         offset, rd_dat;
    logic [2:0]         reg_sel, vec_idx;
    logic               hit, wr_en, eoi;
    state_t             state;

    assign offset  = port_id - BASE_ADDR;
    assign hit     = offset < 8'd6;
    assign reg_sel = offset[2:0];
    assign wr_en   = write_strobe && hit;
    assign eoi     = wr_en && (reg_sel == REG_EOI);
    assign clr     = (wr_en && reg_sel == REG_CLEAR) ? out_port[NUM_IRQ-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign filled = (fill_cnt == FILL_CNT);
    // A channel only reports edges once it has been seen low after the synchroniser refilled,
    // so a line held high across reset does not masquerade as a fresh rising edge.
    assign rise   = s & ~s_prev & armed;

    // Set beats clear: an edge arriving with a CLEAR write still leaves the channel pending.
    assign pending_nxt = (mode & ((pending & ~clr) | rise)) | (~mode & s);
    assign act         = pending & mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev   <= '0;
            armed    <= '0;
            fill_cnt <= '0;
            pending  <= '0;
            mask     <= '0;
            mode     <= '0;
        end else begin
            s_prev   <= s;
            armed    <= armed | ({NUM_IRQ{filled}} & ~s);
            if (!filled) fill_cnt <= fill_cnt + 2'd1;
            pending  <= pending_nxt;
            if (wr_en && reg_sel == REG_MASK) mask <= out_port[NUM_IRQ-1:0];
            if (wr_en && reg_sel == REG_MODE) mode <= out_port[NUM_IRQ-1:0];
        end
    end

    always_comb begin
        vec_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (act[i]) vec_idx = 3'(i);
        end
    end

    always_comb begin
        rd_dat = '0;
        case (reg_sel)
            REG_STATUS: rd_dat = 8'(pending);
            REG_MASK:   rd_dat = 8'(mask);
            REG_MODE:   rd_dat = 8'(mode);
            REG_VECTOR: rd_dat = {|act, 4'b0000, vec_idx};
            default:    rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_port <= '0;
            sel     <= 1'b0;
        end else begin
            in_port <= hit ? rd_dat : 8'h00;
            sel     <= hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|act) begin
                        state     <= REQ;
                        interrupt <= 1'b1;
                    end
                end
                REQ: begin
                    if (interrupt_ack) begin
                        state     <= SERVICE;
                        interrupt <= 1'b0;
                    end else if (!(|act)) begin
                        state     <= IDLE;
                        interrupt <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

    // The core never issues input and output strobes in the same cycle.
    assert property (@(posedge clk) disable iff (rst) !(read_strobe && write_strobe));

endmodule

// File: tb/tb_pblaze_intc.sv
// Bench for pblaze_intc: register table, directed corner sequences, then randomized traffic vs a reference model.
module tb_pblaze_intc;
    localparam int         NI   = 8;
    localparam int         SS   = 2;
    localparam logic [7:0] BASE = 8'h10;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] irq_in;
    logic [7:0]    port_id, out_port, in_port;
    logic          write_strobe, read_strobe, sel, interrupt, interrupt_ack;

    int n_chk  = 0;
    int n_fail = 0;

    pblaze_intc #(.NUM_IRQ(NI), .BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .port_id(port_id),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .out_port(out_port),
        .in_port(in_port), .sel(sel), .interrupt(interrupt), .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a; out_port = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0; out_port = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic s);
        port_id = a; read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        d = in_port; s = sel;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       s;
        rd(a, d, s);
        check(name, d, exp);
    endtask

    task automatic wait_int(input logic lvl, input int max_cyc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (interrupt === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_pulse();
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
    endtask

    task automatic reset_dut(input logic [7:0] irq);
        irq_in = irq; rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] dat;
        logic [7:0] exp;
        logic       exp_sel;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] d;
    logic       sv, ok;

    // reference model state for the randomized phase
    logic [7:0] hist[$];
    logic [7:0] m_pend, m_mask, m_mode, m_act, m_clr, m_new, s_now, s_old, off, e_in;
    logic       m_int, e_sel, m_eoi;
    int         m_st;   // 0 idle, 1 requesting, 2 in service
    int         kind;

    initial begin
        rst = 1'b1; irq_in = '0; port_id = '0; out_port = '0;
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(SS + 3);

        // ---------------- register map table ----------------
        tbl.push_back('{1'b1, 8'h11, 8'hA5, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h11, 8'h00, 8'hA5, 1'b1});
        tbl.push_back('{1'b1, 8'h12, 8'h3C, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h12, 8'h00, 8'h3C, 1'b1});
        tbl.push_back('{1'b0, 8'h10, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h13, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h14, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h15, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h0F, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h16, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h16, 8'hFF, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 8'h0F, 8'h00, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 8'h11, 8'h00, 8'hA5, 1'b1});
        tbl.push_back('{1'b1, 8'h11, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b1, 8'h12, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h11, 8'h00, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 8'h12, 8'h00, 8'h00, 1'b1});
        foreach (tbl[i]) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].addr, tbl[i].dat);
            end else begin
                rd(tbl[i].addr, d, sv);
                check("tbl_data", d, tbl[i].exp);
                check("tbl_sel", 8'(sv), 8'(tbl[i].exp_sel));
            end
        end

        // ---------------- 1: reset with all requests high ----------------
        reset_dut(8'hFF);
        check("t1_int_rst", 8'(interrupt), 8'h00);
        check("t1_sel_rst", 8'(sel), 8'h00);
        rd_chk("t1_status_early", 8'h10, 8'h00);
        cyc(SS + 1);
        rd_chk("t1_status_level", 8'h10, 8'hFF);
        wr(8'h12, 8'hFF);
        wr(8'h13, 8'hFF);
        rd_chk("t1_status_edge", 8'h10, 8'h00);
        check("t1_int", 8'(interrupt), 8'h00);

        // ---------------- 2: single pulse on channel 2 ----------------
        irq_in = '0;
        cyc(SS + 3);
        wr(8'h11, 8'h04);
        irq_in = 8'h04;
        @(negedge clk);
        irq_in = 8'h00;
        wait_int(1'b1, SS + 3, ok);
        check("t2_int_rise", 8'(ok), 8'h01);
        rd_chk("t2_status", 8'h10, 8'h04);
        rd_chk("t2_vector", 8'h14, 8'h82);
        cyc(3);
        check("t2_int_held", 8'(interrupt), 8'h01);
        ack_pulse();
        check("t2_int_ack", 8'(interrupt), 8'h00);
        wr(8'h13, 8'h04);
        wr(8'h15, 8'h00);
        cyc(4);
        check("t2_int_after_eoi", 8'(interrupt), 8'h00);

        // ---------------- 3: priority and EOI re-assertion ----------------
        wr(8'h11, 8'hFF);
        irq_in = 8'h22;
        @(negedge clk);
        irq_in = 8'h00;
        wait_int(1'b1, SS + 4, ok);
        check("t3_int_rise", 8'(ok), 8'h01);
        rd_chk("t3_vector_hi", 8'h14, 8'h81);
        ack_pulse();
        wr(8'h13, 8'h02);
        rd_chk("t3_vector_lo", 8'h14, 8'h85);
        check("t3_int_service", 8'(interrupt), 8'h00);
        wr(8'h15, 8'h00);
        check("t3_eoi_c1", 8'(interrupt), 8'h00);
        @(negedge clk);
        check("t3_eoi_c2", 8'(interrupt), 8'h01);
        ack_pulse();
        wr(8'h13, 8'h20);
        wr(8'h15, 8'h00);
        cyc(3);
        check("t3_int_done", 8'(interrupt), 8'h00);

        // ---------------- 4: edge collides with CLEAR ----------------
        wr(8'h11, 8'h00);
        irq_in = 8'h08;
        cyc(SS);
        wr(8'h13, 8'h08);
        rd_chk("t4_set_wins", 8'h10, 8'h08);
        wr(8'h13, 8'h08);
        rd_chk("t4_cleared", 8'h10, 8'h00);

        // ---------------- 5: level request withdrawn before ack ----------------
        irq_in = 8'h00;
        wr(8'h12, 8'h00);
        wr(8'h11, 8'h01);
        cyc(SS + 2);
        irq_in = 8'h01;
        wait_int(1'b1, SS + 4, ok);
        check("t5_int_rise", 8'(ok), 8'h01);
        irq_in = 8'h00;
        wait_int(1'b0, SS + 4, ok);
        check("t5_int_fall", 8'(ok), 8'h01);
        rd_chk("t5_vector", 8'h14, 8'h00);
        ack_pulse();
        cyc(2);
        check("t5_stray_ack", 8'(interrupt), 8'h00);
        irq_in = 8'h01;
        wait_int(1'b1, SS + 4, ok);
        check("t5_int_again", 8'(ok), 8'h01);

        // ---------------- 6: asynchronous reset during service ----------------
        ack_pulse();
        irq_in  = 8'h41;
        port_id = 8'h10;
        cyc(SS + 3);
        check("t6_status_pre", in_port, 8'h41);
        #2 rst = 1'b1;
        #1;
        check("t6_int_async", 8'(interrupt), 8'h00);
        check("t6_inport_async", in_port, 8'h00);
        check("t6_sel_async", 8'(sel), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        cyc(SS + 1);
        rd_chk("t6_status_level", 8'h10, 8'h41);
        rd_chk("t6_mask", 8'h11, 8'h00);
        rd_chk("t6_mode", 8'h12, 8'h00);
        check("t6_int_idle", 8'(interrupt), 8'h00);
        wr(8'h12, 8'hFF);
        wr(8'h13, 8'hFF);
        wr(8'h11, 8'hFF);
        cyc(5);
        check("t6_no_false_edge", 8'(interrupt), 8'h00);
        rd_chk("t6_status_edge", 8'h10, 8'h00);
        irq_in = 8'h00;
        cyc(SS + 2);
        irq_in = 8'h40;
        wait_int(1'b1, SS + 4, ok);
        check("t6_real_edge", 8'(ok), 8'h01);
        rd_chk("t6_vector", 8'h14, 8'h86);

        // ---------------- randomized traffic vs reference model ----------------
        reset_dut(8'h00);
        cyc(SS + 4);
        m_pend = '0; m_mask = '0; m_mode = '0; m_st = 0; m_int = 1'b0;
        hist.delete();
        repeat (SS + 2) hist.push_back(8'h00);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 4) == 0) irq_in = irq_in ^ (8'h01 << $urandom_range(0, 7));
            interrupt_ack = ($urandom_range(0, 7) == 0);
            kind = $urandom_range(0, 3);
            write_strobe = 1'b0; read_strobe = 1'b0; out_port = 8'h00;
            if (kind == 0) begin
                write_strobe = 1'b1;
                port_id      = BASE + 8'($urandom_range(0, 5));
                out_port     = 8'($urandom);
            end else begin
                read_strobe = (kind == 1);
                port_id     = 8'h0E + 8'($urandom_range(0, 9));
            end

            // expected view of the edge about to happen, from the request history
            hist.push_back(irq_in);
            if (hist.size() > 16) void'(hist.pop_front());
            s_now = hist[hist.size() - 1 - SS];
            s_old = hist[hist.size() - 2 - SS];
            off   = port_id - BASE;
            m_act = m_pend & m_mask;
            e_sel = (off < 8'd6);
            e_in  = 8'h00;
            if (e_sel) begin
                case (off)
                    8'd0: e_in = m_pend;
                    8'd1: e_in = m_mask;
                    8'd2: e_in = m_mode;
                    8'd4: begin
                        for (int i = NI - 1; i >= 0; i--) if (m_act[i]) e_in = 8'h80 | 8'(i);
                    end
                    default: e_in = 8'h00;
                endcase
            end
            m_eoi = write_strobe && off == 8'd5;
            m_clr = (write_strobe && off == 8'd3) ? out_port : 8'h00;
            if (m_st == 0) begin
                if (m_act != 0) begin m_st = 1; m_int = 1'b1; end
            end else if (m_st == 1) begin
                if (interrupt_ack) begin m_st = 2; m_int = 1'b0; end
                else if (m_act == 0) begin m_st = 0; m_int = 1'b0; end
            end else if (m_eoi) begin
                m_st = 0;
            end
            for (int i = 0; i < NI; i++) begin
                if (m_mode[i]) m_new[i] = (m_pend[i] && !m_clr[i]) || (s_now[i] && !s_old[i]);
                else           m_new[i] = s_now[i];
            end
            m_pend = m_new;
            if (write_strobe && off == 8'd1) m_mask = out_port;
            if (write_strobe && off == 8'd2) m_mode = out_port;

            @(negedge clk);
            check("rnd_int", 8'(interrupt), 8'(m_int));
            check("rnd_inport", in_port, e_in);
            check("rnd_sel", 8'(sel), 8'(e_sel));
        end
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pblaze_intc.md
Name: pblaze_intc

Overview:
Parametrised interrupt controller between NUM_IRQ peripheral request lines and the single interrupt input of the pacoblaze core in the bamse SoC. It replaces the single bare irq line with synchronised, per-channel edge or level sources. Each source has a mask, pending and priority-vector registers that firmware reads and writes through the port_id/strobe bus. An EOI handshake controls re-assertion of the core interrupt.

Parameters:
NUM_IRQ, 8, number of request channels (1..8); lowest index has highest priority.
BASE_ADDR, 8'h10, port_id of register 0; the block decodes BASE_ADDR..BASE_ADDR+5.
SYNC_STAGES, 2, synchroniser depth on irq_in (2..3).

Ports:
clk  in  1  system clock
rst  in  1  reset (see Behaviour)
irq_in  in  NUM_IRQ  asynchronous peripheral requests
port_id  in  8  core port address
write_strobe  in  1  core output strobe, one cycle
read_strobe  in  1  core input strobe, one cycle
out_port  in  8  core write data
in_port  out  8  register read data
sel  out  1  registered "in_port belongs to this block" flag for the bus mux
interrupt  out  1  to core interrupt input
interrupt_ack  in  1  from core, one-cycle pulse

Behaviour:
- Reset: one clock, clk; rst is asynchronous and active-high. All flops clear at reset: interrupt=0, in_port=0, sel=0, pending=0, mask=0, mode=0, synchronisers=0, FSM=IDLE. Mid-operation reset abandons any in-flight interrupt; no edge is recorded from the sync flops after release until a real 0->1 occurs.
- Sync: irq_in passes through SYNC_STAGES flops, giving s. The previous value is kept for edge detection.
- Registers (offset from BASE_ADDR):
  - 0 STATUS (R): pending.
  - 1 MASK (RW): 1 = enabled.
  - 2 MODE (RW): 1 = rising-edge, 0 = level.
  - 3 CLEAR (W): write-1-to-clear pending for edge channels.
  - 4 VECTOR (R): bit7 = any (pending & mask); bits2:0 = index of the lowest-numbered set bit, else 0.
  - 5 EOI (W, any data): end of interrupt.
  - Bits at or above NUM_IRQ read 0 and ignore writes. Unmapped offsets are ignored.
- Pending, per channel i:
  - Level mode: pending[i] = s[i] each cycle; CLEAR has no effect.
  - Edge mode: set on s rising. Cleared by CLEAR bit i. If set and clear occur in the same cycle, set wins.
  - Changing mode from edge to level takes the level value next cycle.
  - Masked channels still latch pending.
- Reads: in_port and sel are registered every cycle from the port_id decode, so data is valid 1 cycle after port_id, within the core's 2-cycle port window. sel=1 iff port_id is in range. Reads have no side effects; read_strobe is used only for assertions.
- Writes take effect on the clk edge where write_strobe=1 and the address matches.
- FSM:
  - IDLE: if (pending & mask) != 0, go to REQ next cycle.
  - REQ: interrupt=1; on interrupt_ack go to SERVICE. If (pending & mask) becomes 0 before the ack, return to IDLE with interrupt=0.
  - SERVICE: interrupt=0; ignore new requests; on EOI write go to IDLE.
  - EOI received in IDLE or REQ is ignored.
  - Re-assertion after EOI with a request still active: interrupt rises 2 cycles after the EOI write edge (IDLE, then REQ).
- interrupt is a registered FSM output; minimum latency from a synchronised request to interrupt=1 is 2 cycles.

Test Plan:
1. Reset with irq_in=8'hFF, release rst -> interrupt=0, STATUS reads 8'h00 in edge mode and 8'hFF in level mode after SYNC_STAGES+1 cycles.
2. MODE=8'hFF, MASK=8'h04, 1-cycle pulse on irq_in[2] -> STATUS=8'h04, VECTOR=8'h82, interrupt=1 within SYNC_STAGES+3 cycles, held until interrupt_ack. CLEAR 8'h04 then EOI -> interrupt stays 0.
3. Edge mode, simultaneous rising edges on channels 5 and 1, MASK=8'hFF -> VECTOR=8'h81. After CLEAR 8'h02 -> VECTOR=8'h85. After EOI, interrupt re-asserts exactly 2 cycles later.
4. Rising edge on channel 3 in the same cycle as a CLEAR write of 8'h08 -> pending[3] stays 1.
5. Level mode, MASK=8'h01, irq_in[0] high then dropped before the ack -> interrupt falls to 0 and FSM returns to IDLE; ack with no request pending has no effect.
6. Assert rst mid-SERVICE with channels pending -> all registers 0 immediately (asynchronous), interrupt=0; after release, no interrupt unless a new edge or level arrives with its mask set.
